// File: rtl/axi_rd_default_slave.sv
// AXI read-side default slave: accepts an AR request and answers ARLEN+1 DECERR beats with zero data.
// Optional DEFSLV_ERRLOG_EN adds ERR_CNT/ERR_ADDR logging of accepted requests.
module axi_rd_default_slave #(
    parameter int          ID_BITS     = 8,
    parameter int          LEN_BITS    = 4,
    parameter int          DATA_BITS   = 32,
    parameter logic [1:0]  RESP_DECERR = 2'b11
) (
    input  logic                 ACLK,
    input  logic                 ARESET,
    input  logic [ID_BITS-1:0]   ARID,
    input  logic [31:0]          ARADDR,
    input  logic [LEN_BITS-1:0]  ARLEN,
    input  logic [2:0]           ARSIZE,
    input  logic [1:0]           ARBURST,
    input  logic                 ARVALID,
    output logic                 ARREADY,
    output logic [ID_BITS-1:0]   RID,
    output logic [DATA_BITS-1:0] RDATA,
    output logic [1:0]           RRESP,
    output logic                 RLAST,
    output logic                 RVALID,
    input  logic                 RREADY
`ifdef DEFSLV_ERRLOG_EN
    ,
    output logic [15:0]          ERR_CNT,
    output logic [31:0]          ERR_ADDR
`endif
);

    typedef enum logic {IDLE = 1'b0, RESP = 1'b1} state_t;

    state_t              r_state;
    logic [ID_BITS-1:0]  r_id;
    logic [LEN_BITS-1:0] r_len;
    logic [LEN_BITS-1:0] r_beat_cnt;

    logic w_ar_hs;
    logic w_r_hs;
    logic w_last;

    // Outputs decode straight from state so an async reset silences the channel at once.
    assign ARREADY = (r_state == IDLE) && !ARESET;
    assign RVALID  = (r_state == RESP);
    assign w_last  = (r_beat_cnt == r_len);
    assign RLAST   = RVALID && w_last;
    assign RID     = r_id;
    assign RDATA   = '0;
    assign RRESP   = RESP_DECERR;

    assign w_ar_hs = ARVALID && ARREADY;
    assign w_r_hs  = RVALID && RREADY;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state    <= IDLE;
            r_id       <= '0;
            r_len      <= '0;
            r_beat_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ar_hs) begin
                        r_id       <= ARID;
                        r_len      <= ARLEN;
                        r_beat_cnt <= '0;
                        r_state    <= RESP;
                    end
                end
                RESP: begin
                    if (w_r_hs) begin
                        if (w_last) r_state <= IDLE;
                        else        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef DEFSLV_ERRLOG_EN
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            ERR_CNT  <= '0;
            ERR_ADDR <= '0;
        end else if (w_ar_hs) begin
            ERR_ADDR <= ARADDR;
            if (ERR_CNT != 16'hFFFF) ERR_CNT <= ERR_CNT + 16'd1;
        end
    end

    logic w_unused;
    assign w_unused = ^{ARSIZE, ARBURST};
`else
    // Size, burst type and address play no part in the response.
    logic w_unused;
    assign w_unused = ^{ARSIZE, ARBURST, ARADDR};
`endif

endmodule
